// File: rtl/reg_bank_mux.sv
// reg_bank_mux
//   Register bank of NREGS x WIDTH general registers with a registered,
//   valid/ready handshaked operand-select port. On each accepted request the
//   selected source is captured into a single output register.
//   Select decode:
//     sel <  NREGS  -> reg[sel]
//     sel == NREGS  -> immediate
//     sel == NREGS+1 -> default value
//     otherwise     -> zero, with o_out_err set
//   A same-cycle write to the selected register is forwarded to the output.
//
// Ports
//   i_clk        clock, all state updates on rising edge
//   i_reset_n    synchronous active-low reset
//   i_wr_en      register write strobe
//   i_wr_addr    register write index (indices >= NREGS are ignored)
//   i_wr_data    register write data
//   i_req_valid  select request valid
//   o_req_ready  request can be accepted this cycle
//   i_sel        source select
//   i_im_d       immediate operand
//   i_def_val    default operand
//   o_out_valid  o_out_data holds an unconsumed result
//   i_out_ready  consumer accepts o_out_data this cycle
//   o_out_data   selected operand
//   o_out_err    captured request used an undefined select
module reg_bank_mux #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREGS = 8,
    parameter int unsigned SEL_W = 4,
    parameter int unsigned AW    = 3
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [SEL_W-1:0] i_sel,
    input  logic [WIDTH-1:0] i_im_d,
    input  logic [WIDTH-1:0] i_def_val,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_err
);

    localparam logic [SEL_W-1:0] SEL_IMM = SEL_W'(NREGS);
    localparam logic [SEL_W-1:0] SEL_DEF = SEL_W'(NREGS + 1);

    logic [WIDTH-1:0] r_regs [NREGS];
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_err;

    logic             w_accept;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_err;

    // Single output register: it can take a new request whenever it is empty
    // or being drained in this same cycle.
    assign o_req_ready = !r_out_valid || i_out_ready;
    assign w_accept    = i_req_valid && o_req_ready;

    // Source decode. Register reads compare against each index explicitly so
    // that out-of-range selects never alias onto a real register, and a write
    // landing on the selected register this cycle wins over the stored value.
    always_comb begin
        w_sel_data = '0;
        w_sel_err  = 1'b0;
        if (i_sel == SEL_IMM) begin
            w_sel_data = i_im_d;
        end else if (i_sel == SEL_DEF) begin
            w_sel_data = i_def_val;
        end else if (i_sel < SEL_IMM) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (i_sel == SEL_W'(i)) begin
                    if (i_wr_en && (i_wr_addr == AW'(i))) begin
                        w_sel_data = i_wr_data;
                    end else begin
                        w_sel_data = r_regs[i];
                    end
                end
            end
        end else begin
            w_sel_err = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_regs      <= '{default: '0};
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
        end else begin
            // Write addresses with no matching index simply hit no register.
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (i_wr_en && (i_wr_addr == AW'(i))) begin
                    r_regs[i] <= i_wr_data;
                end
            end

            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_err   <= w_sel_err;
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_err   = r_out_err;

endmodule

// File: tb/tb_reg_bank_mux.sv
// Directed bench for reg_bank_mux: a default build (NREGS=8) plus a second
// NREGS=6 build used for the out-of-range write case.
module tb_reg_bank_mux;

    localparam int unsigned WIDTH = 16;

    logic clk;
    logic reset_n;

    // Main DUT (NREGS=8, SEL_W=4, AW=3)
    logic             wr_en;
    logic [2:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       sel;
    logic [WIDTH-1:0] im_d;
    logic [WIDTH-1:0] def_val;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_err;

    // Second DUT (NREGS=6, SEL_W=4, AW=3)
    logic             b_wr_en;
    logic [2:0]       b_wr_addr;
    logic [WIDTH-1:0] b_wr_data;
    logic             b_req_valid;
    logic             b_req_ready;
    logic [3:0]       b_sel;
    logic [WIDTH-1:0] b_im_d;
    logic [WIDTH-1:0] b_def_val;
    logic             b_out_valid;
    logic             b_out_ready;
    logic [WIDTH-1:0] b_out_data;
    logic             b_out_err;

    int n_cmp;
    int n_err;

    logic [WIDTH-1:0] exp_vals [8];

    reg_bank_mux #(
        .WIDTH(WIDTH), .NREGS(8), .SEL_W(4), .AW(3)
    ) u_dut (
        .i_clk      (clk),
        .i_reset_n  (reset_n),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .i_req_valid(req_valid),
        .o_req_ready(req_ready),
        .i_sel      (sel),
        .i_im_d     (im_d),
        .i_def_val  (def_val),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_out_data (out_data),
        .o_out_err  (out_err)
    );

    reg_bank_mux #(
        .WIDTH(WIDTH), .NREGS(6), .SEL_W(4), .AW(3)
    ) u_dut6 (
        .i_clk      (clk),
        .i_reset_n  (reset_n),
        .i_wr_en    (b_wr_en),
        .i_wr_addr  (b_wr_addr),
        .i_wr_data  (b_wr_data),
        .i_req_valid(b_req_valid),
        .o_req_ready(b_req_ready),
        .i_sel      (b_sel),
        .i_im_d     (b_im_d),
        .i_def_val  (b_def_val),
        .o_out_valid(b_out_valid),
        .i_out_ready(b_out_ready),
        .o_out_data (b_out_data),
        .o_out_err  (b_out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        req_valid = 1'b0; sel = '0; im_d = '0; def_val = '0; out_ready = 1'b0;
        b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
        b_req_valid = 1'b0; b_sel = '0; b_im_d = '0; b_def_val = '0; b_out_ready = 1'b1;

        tick();
        tick();
        reset_n = 1'b1;
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data",  {16'd0, out_data},  32'd0);
        chk("rst_err",   {31'd0, out_err},   32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);

        // Basic write then read
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234;
        tick();
        wr_en = 1'b0;
        out_ready = 1'b1;
        req_valid = 1'b1; sel = 4'd3;
        tick();
        chk("rd3_valid", {31'd0, out_valid}, 32'd1);
        chk("rd3_data",  {16'd0, out_data},  32'h1234);
        chk("rd3_err",   {31'd0, out_err},   32'd0);
        sel = 4'd5;
        tick();
        chk("rd5_data",  {16'd0, out_data},  32'h0000);

        // Immediate, default, illegal select
        sel = 4'd8; im_d = 16'hBEEF;
        tick();
        chk("imm_data", {16'd0, out_data}, 32'hBEEF);
        sel = 4'd9; def_val = 16'h00FF;
        tick();
        chk("def_data", {16'd0, out_data}, 32'h00FF);
        chk("def_err",  {31'd0, out_err},  32'd0);
        sel = 4'd12;
        tick();
        chk("ill_data", {16'd0, out_data}, 32'h0000);
        chk("ill_err",  {31'd0, out_err},  32'd1);
        sel = 4'd15;
        tick();
        chk("ill15_err", {31'd0, out_err}, 32'd1);
        sel = 4'd3;
        tick();
        chk("err_clr", {31'd0, out_err}, 32'd0);
        req_valid = 1'b0;

        // Forwarding
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h1111;
        tick();
        wr_data = 16'h2222;
        req_valid = 1'b1; sel = 4'd2;
        tick();
        chk("fwd_data", {16'd0, out_data}, 32'h2222);
        wr_en = 1'b0;
        tick();
        chk("fwd_after", {16'd0, out_data}, 32'h2222);
        req_valid = 1'b0;
        tick();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h4444;
        tick();
        wr_en = 1'b0;
        out_ready = 1'b0;
        req_valid = 1'b1; sel = 4'd4;
        tick();
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_data",  {16'd0, out_data},  32'h4444);
        for (int k = 0; k < 5; k++) begin
            wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h5555 + 16'(k);
            #1;
            chk("bp_ready", {31'd0, req_ready}, 32'd0);
            tick();
            chk("bp_hold_data",  {16'd0, out_data},  32'h4444);
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        end
        wr_en = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
        tick();
        chk("bp_release_data",  {16'd0, out_data},  32'h5559);
        chk("bp_release_valid", {31'd0, out_valid}, 32'd1);
        req_valid = 1'b0;
        tick();

        // Throughput: load all registers, then read one per cycle
        for (int i = 0; i < 8; i++) begin
            exp_vals[i] = 16'hA000 + 16'(i * 16'h0111);
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = exp_vals[i];
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; sel = 4'(i);
            tick();
            chk("tp_valid", {31'd0, out_valid}, 32'd1);
            chk("tp_data",  {16'd0, out_data},  {16'd0, exp_vals[i]});
        end
        req_valid = 1'b0;
        tick();
        chk("tp_end_valid", {31'd0, out_valid}, 32'd0);

        // Reset mid-transfer, with a same-cycle write that must be dropped
        out_ready = 1'b0;
        req_valid = 1'b1; sel = 4'd3;
        tick();
        chk("mr_valid_pre", {31'd0, out_valid}, 32'd1);
        req_valid = 1'b0;
        reset_n = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'hFFFF;
        tick();
        reset_n = 1'b1;
        wr_en = 1'b0;
        #1;
        chk("mr_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_data",  {16'd0, out_data},  32'd0);
        chk("mr_ready", {31'd0, req_ready}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; sel = 4'(i);
            tick();
            chk("mr_reg_zero", {16'd0, out_data}, 32'd0);
        end
        req_valid = 1'b0;
        tick();

        // NREGS=6 build: out-of-range writes must not touch any register
        for (int i = 0; i < 6; i++) begin
            b_wr_en = 1'b1; b_wr_addr = 3'(i); b_wr_data = 16'h0C00 + 16'(i);
            tick();
        end
        b_wr_addr = 3'd6; b_wr_data = 16'hDEAD;
        tick();
        b_wr_addr = 3'd7; b_wr_data = 16'hBEEF;
        tick();
        b_wr_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            b_req_valid = 1'b1; b_sel = 4'(i);
            tick();
            chk("oor_reg", {16'd0, b_out_data}, {16'd0, 16'h0C00 + 16'(i)});
        end
        b_sel = 4'd6; b_im_d = 16'h0ABC;
        tick();
        chk("n6_imm", {16'd0, b_out_data}, 32'h0ABC);
        b_sel = 4'd7; b_def_val = 16'h1357;
        tick();
        chk("n6_def", {16'd0, b_out_data}, 32'h1357);
        b_sel = 4'd8;
        tick();
        chk("n6_ill_err",  {31'd0, b_out_err},  32'd1);
        chk("n6_ill_data", {16'd0, b_out_data}, 32'd0);
        b_req_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
